// File: rtl/output_arbiter.sv
// Credit-based round-robin output port arbiter: pops one eligible input queue per cycle while
// downstream credit remains. Optional macro OUTPUT_ARBITER_ANT_PRIORITY_EN favours backward ants.
package output_arbiter_pkg;
  typedef struct packed {
    logic        ant;
    logic        backward;
    logic [13:0] payload;
  } packet_t;
endpackage

module output_arbiter #(
  parameter int unsigned N_IN       = 5,
  parameter int unsigned CREDIT_MAX = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ce,
  input  output_arbiter_pkg::packet_t   i_data [N_IN],
  input  logic [N_IN-1:0]               i_data_val,
  input  logic [N_IN-1:0]               i_req,
  input  logic                          i_credit_ret,
  output logic [N_IN-1:0]               o_en,
  output output_arbiter_pkg::packet_t   o_data,
  output logic                          o_data_val,
  output logic [3:0]                    o_credit,
  output logic                          o_err
);

  localparam int unsigned PtrW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [3:0] CreditMax = 4'(CREDIT_MAX);

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]      credit_q, credit_d;
  logic            err_d;
  logic            data_val_d;
  output_arbiter_pkg::packet_t data_d;

  logic [N_IN-1:0] eligible;
  logic [N_IN-1:0] cand;
  logic [PtrW-1:0] win_idx;
  logic [PtrW-1:0] idx;
  logic [PtrW:0]   sum;
  logic            found;
  logic            grant;

  always_comb begin
    eligible = i_req & i_data_val;
`ifdef OUTPUT_ARBITER_ANT_PRIORITY_EN
    begin
      logic [N_IN-1:0] prio;
      prio = '0;
      for (int k = 0; k < int'(N_IN); k++) begin
        prio[k] = eligible[k] & i_data[k].ant & i_data[k].backward;
      end
      cand = (|prio) ? prio : eligible;
    end
`else
    cand = eligible;
`endif
    // Scan from rr_ptr upward, wrapping at N_IN.
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      sum = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
      if (sum >= (PtrW+1)'(N_IN)) sum = sum - (PtrW+1)'(N_IN);
      idx = sum[PtrW-1:0];
      if (!found && cand[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    grant = ce & reset_n & (credit_q != '0) & found;
    o_en  = '0;
    if (grant) o_en[win_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    credit_d   = credit_q;
    err_d      = o_err;
    data_d     = o_data;
    data_val_d = o_data_val;
    if (ce) begin
      data_val_d = grant;
      if (grant) begin
        data_d   = i_data[win_idx];
        rr_ptr_d = (win_idx == PtrW'(N_IN - 1)) ? '0 : win_idx + 1'b1;
      end
      if (grant && !i_credit_ret) begin
        credit_d = credit_q - 4'd1;
      end else if (!grant && i_credit_ret) begin
        if (credit_q >= CreditMax) err_d = 1'b1;
        else                       credit_d = credit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      credit_q   <= CreditMax;
      o_err      <= 1'b0;
      o_data     <= '0;
      o_data_val <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      credit_q   <= credit_d;
      o_err      <= err_d;
      o_data     <= data_d;
      o_data_val <= data_val_d;
    end
  end

  assign o_credit = credit_q;

endmodule
